// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter plus fetch stage feeding a combinational instruction ROM.
// Registers the returned word and splits it into decode fields. Redirects from execute flush one slot.
`default_nettype none

module instruction_fetch #(
  parameter int ADDR_W   = 16,
  parameter int INSTR_W  = 28,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  address,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instruction,
  output logic [3:0]         opcode,
  output logic [7:0]         dest,
  output logic [7:0]         src_a,
  output logic [7:0]         src_b,
  output logic [15:0]        imm,
  output logic [ADDR_W-1:0]  pc,
  output logic               valid
);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  state_t              state;
  logic [ADDR_W-1:0]   pc_next;
  logic [INSTR_W-1:0]  ir;
  logic [ADDR_W-1:0]   ir_pc;
  logic                ir_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_START;
      pc_next  <= PC_INIT;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      case (state)
        // The first fetch after reset ignores both stall and redirect.
        S_START: begin
          ir       <= rom_data;
          ir_pc    <= pc_next;
          pc_next  <= pc_next + PC_ONE;
          ir_valid <= 1'b1;
          state    <= S_RUN;
        end
        S_RUN, S_FLUSH: begin
          if (branch_taken) begin
            pc_next  <= branch_target;
            ir       <= '0;
            ir_valid <= 1'b0;
            state    <= S_FLUSH;
          end else if (!stall) begin
            ir       <= rom_data;
            ir_pc    <= pc_next;
            pc_next  <= pc_next + PC_ONE;
            ir_valid <= 1'b1;
            state    <= S_RUN;
          end
        end
        default: begin
          state    <= S_START;
          pc_next  <= PC_INIT;
          ir       <= '0;
          ir_pc    <= '0;
          ir_valid <= 1'b0;
        end
      endcase
    end
  end

  assign address     = pc_next;
  assign instruction = ir;
  assign opcode      = ir[27:24];
  assign dest        = ir[23:16];
  assign src_a       = ir[15:8];
  assign src_b       = ir[7:0];
  assign imm         = ir[15:0];
  assign pc          = ir_pc;
  assign valid       = ir_valid;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by random stall/branch/reset traffic.
`default_nettype none

module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] address;
  logic [27:0] rom_data;
  logic [27:0] instruction;
  logic [3:0]  opcode;
  logic [7:0]  dest;
  logic [7:0]  src_a;
  logic [7:0]  src_b;
  logic [15:0] imm;
  logic [15:0] pc;
  logic        valid;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Reference state: what the fetch stage should be showing right now.
  logic [15:0] m_pc;
  logic [27:0] m_ir;
  logic [15:0] m_opc;
  logic        m_valid;
  logic        m_first;

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_W(16), .INSTR_W(28), .RESET_PC(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .address       (address),
    .rom_data      (rom_data),
    .instruction   (instruction),
    .opcode        (opcode),
    .dest          (dest),
    .src_a         (src_a),
    .src_b         (src_b),
    .imm           (imm),
    .pc            (pc),
    .valid         (valid)
  );

  function automatic logic [27:0] rom_word(input logic [15:0] a);
    if (a >= 16'd1024) return 28'h0C0FFEE;
    return {a[3:0], a[7:0] ^ 8'h5A, a[15:8] + a[7:0], ~a[7:0]};
  endfunction

  assign rom_data = rom_word(address);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".address"}, 32'(address), 32'(m_pc));
    check({tag, ".instr"},   32'(instruction), 32'(m_ir));
    check({tag, ".opcode"},  32'(opcode), 32'(m_ir[27:24]));
    check({tag, ".dest"},    32'(dest), 32'(m_ir[23:16]));
    check({tag, ".src_a"},   32'(src_a), 32'(m_ir[15:8]));
    check({tag, ".src_b"},   32'(src_b), 32'(m_ir[7:0]));
    check({tag, ".imm"},     32'(imm), 32'(m_ir[15:0]));
    check({tag, ".pc"},      32'(pc), 32'(m_opc));
    check({tag, ".valid"},   32'(valid), 32'(m_valid));
  endtask

  task automatic model_reset();
    m_pc = 16'd0; m_ir = '0; m_opc = 16'd0; m_valid = 1'b0; m_first = 1'b1;
  endtask

  // One clock: inputs are applied at the falling edge and outputs checked at the next one.
  task automatic step(input logic st, input logic br, input logic [15:0] tgt, input string tag);
    stall = st; branch_taken = br; branch_target = tgt;
    @(posedge clk);
    if (m_first) begin
      m_ir = rom_word(m_pc); m_opc = m_pc; m_pc = m_pc + 16'd1; m_valid = 1'b1; m_first = 1'b0;
    end else if (br) begin
      m_pc = tgt; m_ir = '0; m_valid = 1'b0;
    end else if (!st) begin
      m_ir = rom_word(m_pc); m_opc = m_pc; m_pc = m_pc + 16'd1; m_valid = 1'b1;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  // Reset pulse placed mid-cycle so the asynchronous path is exercised.
  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
    check_all({tag, ".rel"});
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    check(">release.address", 32'(address), 32'd0);

    // Straight-line fetch from reset.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'd0, "seq");
    check("seq.address3", 32'(address), 32'd3);
    check("seq.pc_lag", 32'(pc), 32'd2);

    // Stall three cycles at PC=5.
    while (m_pc != 16'd5) step(1'b0, 1'b0, 16'd0, "to5");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'd0, "stall");
    check("stall.address", 32'(address), 32'd5);
    step(1'b0, 1'b0, 16'd0, "resume");
    check("resume.pc", 32'(pc), 32'd5);
    check("resume.address", 32'(address), 32'd6);

    // Redirect to 8 from PC=10.
    while (m_pc != 16'd10) step(1'b0, 1'b0, 16'd0, "to10");
    step(1'b0, 1'b1, 16'd8, "br8");
    check("br8.address", 32'(address), 32'd8);
    check("br8.valid", 32'(valid), 32'd0);
    check("br8.instr", 32'(instruction), 32'd0);
    step(1'b0, 1'b0, 16'd0, "br8.next");
    check("br8.next.pc", 32'(pc), 32'd8);
    check("br8.next.address", 32'(address), 32'd9);

    // Branch beats stall, then stall holds the bubble.
    step(1'b1, 1'b1, 16'd2, "brst");
    check("brst.address", 32'(address), 32'd2);
    step(1'b1, 1'b0, 16'd0, "flush_stall");
    check("flush_stall.valid", 32'(valid), 32'd0);
    step(1'b0, 1'b0, 16'd0, "flush_exit");
    check("flush_exit.pc", 32'(pc), 32'd2);

    // Wrap at the top of the address space; out-of-range ROM word fetched normally.
    step(1'b0, 1'b1, 16'hFFFF, "wrap.br");
    check("wrap.addr_ffff", 32'(address), 32'h0000FFFF);
    step(1'b0, 1'b0, 16'd0, "wrap.1");
    check("wrap.addr_0", 32'(address), 32'd0);
    check("wrap.dflt", 32'(instruction), 32'h00C0FFEE);
    step(1'b0, 1'b0, 16'd0, "wrap.2");
    check("wrap.noX", 32'($isunknown({address, instruction, pc, valid})), 32'd0);

    // Reset while flushing.
    step(1'b0, 1'b1, 16'd7, "pre_rst");
    mid_reset("rst_flush");
    step(1'b1, 1'b0, 16'd0, "restart");
    check("restart.pc", 32'(pc), 32'd0);

    // Random traffic, including occasional mid-cycle resets.
    for (int i = 0; i < 400; i++) begin
      logic st, br;
      logic [15:0] tgt;
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 6) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1100));
      if ($urandom_range(0, 60) == 0) mid_reset("rnd_rst");
      else step(st, br, tgt, "rnd");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
